wash_plant: RTL

Cycle-based behavioural model of the washing-machine hardware: the drum, water valve, drain pump and heater that the wash controller drives. It consumes the controller's actuator outputs (water_in, wash, drain, speed, heat_r) and produces the sensor inputs the controller waits on (full, cold, empty), plus level/temperature observability and protocol-fault detection. It sits opposite the controller in the top-level FPGA bench and in simulation, closing the loop without real sensors.

---
 rtl/wash_plant_if.sv | 27 ++
 rtl/wash_plant.sv | 134 +++++++++++++
 2 files changed

// File: rtl/wash_plant_if.sv
// Actuator/sensor bundle between the wash controller and the plant model.
// The controller is the master and the plant is the slave.
interface wash_plant_if;
  logic       water_in;
  logic       drain;
  logic       wash;
  logic       speed;
  logic       heat_r;
  logic       clr_fault;
  logic       full;
  logic       empty;
  logic       cold;
  logic [7:0] level;
  logic [7:0] temp;
  logic       fault;
  logic [2:0] fault_code;

  modport master (
    output water_in, drain, wash, speed, heat_r, clr_fault,
    input  full, empty, cold, level, temp, fault, fault_code
  );

  modport slave (
    input  water_in, drain, wash, speed, heat_r, clr_fault,
    output full, empty, cold, level, temp, fault, fault_code
  );
endinterface

// File: rtl/wash_plant.sv
// Behavioural drum/valve/pump/heater model closing the controller loop.
// Define WASH_PLANT_FAULT_EN to compile in sticky protocol-fault checking.
module wash_plant #(
  parameter int LEVEL_MAX    = 200,
  parameter int FILL_DIV     = 250000,
  parameter int DRAIN_DIV    = 125000,
  parameter int HEAT_DIV     = 500000,
  parameter int COOL_DIV     = 2000000,
  parameter int TEMP_AMBIENT = 15,
  parameter int TEMP_WARM    = 40,
  parameter int TEMP_MAX     = 90
) (
  input  logic        clk,
  input  logic        reset,
  wash_plant_if.slave pif
);

  localparam logic [31:0] FILL_TOP  = 32'(FILL_DIV - 1);
  localparam logic [31:0] DRAIN_TOP = 32'(DRAIN_DIV - 1);
  localparam logic [31:0] HEAT_TOP  = 32'(HEAT_DIV - 1);
  localparam logic [31:0] COOL_TOP  = 32'(COOL_DIV - 1);
  localparam logic [7:0]  LMAX      = 8'(LEVEL_MAX);
  localparam logic [7:0]  AMB       = 8'(TEMP_AMBIENT);
  localparam logic [7:0]  WARM      = 8'(TEMP_WARM);
  localparam logic [7:0]  TMAX      = 8'(TEMP_MAX);

  logic [31:0] fill_pre;
  logic [31:0] drain_pre;
  logic [31:0] heat_pre;
  logic [31:0] cool_pre;
  logic [7:0]  level;
  logic [7:0]  temp;

  logic fill_run;
  logic drain_run;
  logic heat_run;
  logic cool_run;
  logic fill_hit;
  logic drain_hit;
  logic heat_hit;
  logic cool_hit;
  logic full;
  logic empty;

  assign full  = (level == LMAX);
  assign empty = (level == 8'd0);

  assign fill_run  = pif.water_in & ~pif.drain;
  assign drain_run = pif.drain & ~pif.water_in;
  assign heat_run  = pif.heat_r & ~empty;
  assign cool_run  = ~heat_run & (temp > AMB);

  assign fill_hit  = fill_run  & (fill_pre  == FILL_TOP);
  assign drain_hit = drain_run & (drain_pre == DRAIN_TOP);
  assign heat_hit  = heat_run  & (heat_pre  == HEAT_TOP);
  assign cool_hit  = cool_run  & (cool_pre  == COOL_TOP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_pre  <= '0;
      drain_pre <= '0;
      heat_pre  <= '0;
      cool_pre  <= '0;
      level     <= '0;
      temp      <= AMB;
    end else begin
      fill_pre  <= (!fill_run  || fill_hit)  ? '0 : fill_pre  + 32'd1;
      drain_pre <= (!drain_run || drain_hit) ? '0 : drain_pre + 32'd1;
      heat_pre  <= (!heat_run  || heat_hit)  ? '0 : heat_pre  + 32'd1;
      cool_pre  <= (!cool_run  || cool_hit)  ? '0 : cool_pre  + 32'd1;

      if (fill_hit && level < LMAX)
        level <= level + 8'd1;
      else if (drain_hit && level != 8'd0)
        level <= level - 8'd1;

      // an empty drum always holds fresh water at ambient
      if (empty)
        temp <= AMB;
      else if (heat_hit && temp < TMAX)
        temp <= temp + 8'd1;
      else if (cool_hit)
        temp <= temp - 8'd1;
    end
  end

  assign pif.full  = full;
  assign pif.empty = empty;
  assign pif.cold  = (temp < WARM);
  assign pif.level = level;
  assign pif.temp  = temp;

`ifdef WASH_PLANT_FAULT_EN
  logic       fault;
  logic [2:0] fault_code;
  logic [2:0] code_d;

  // lowest code takes precedence when several fire together
  always_comb begin
    code_d = 3'd0;
    if (pif.water_in && pif.drain)
      code_d = 3'd1;
    else if ((pif.heat_r || pif.wash) && empty)
      code_d = 3'd2;
    else if (pif.speed && !empty)
      code_d = 3'd3;
    else if (fill_hit && full)
      code_d = 3'd4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault      <= 1'b0;
      fault_code <= 3'd0;
    end else if (pif.clr_fault) begin
      fault      <= 1'b0;
      fault_code <= 3'd0;
    end else if (!fault && code_d != 3'd0) begin
      fault      <= 1'b1;
      fault_code <= code_d;
    end
  end

  assign pif.fault      = fault;
  assign pif.fault_code = fault_code;
`else
  logic unused_fault_inputs;

  assign unused_fault_inputs = &{1'b0, pif.wash, pif.speed, pif.clr_fault};
  assign pif.fault           = 1'b0;
  assign pif.fault_code      = 3'd0;
`endif

endmodule
